debounce_events: RTL and testbench

- Multi-channel successor debouncer for front-panel pushbuttons, DIP switches and other slow board inputs feeding control/status logic.
- Each channel has:
  - an input synchronizer;
  - symmetric press and release qualification;
  - one-cycle press, release and long-press event pulses.
- Outputs are always active-high regardless of input polarity, so downstream logic needs no per-board inversion.

---
 rtl/debounce_events_if.sv | 31 +++
 rtl/debounce_events.sv | 214 +++++++++++++++++++++
 tb/tb_debounce_events.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_events_if.sv
// Bundle of the raw input vector and debounced outputs for debounce_events.
// The master side drives the raw inputs and observes events. The slave side
// is the debouncer itself.
interface debounce_events_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;
    logic [WIDTH-1:0] long_level;

    modport master (
        output data_in,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  long_level
    );

    modport slave (
        input  data_in,
        output level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output long_level
    );
endinterface

// File: rtl/debounce_events.sv
// Multi-channel pushbutton/switch debouncer.
// Each channel has a synchronizer and symmetric press/release qualification.
// It produces registered one-cycle press, release and long-press pulses.
// All outputs are active-high whatever the board polarity of the raw inputs.
module debounce_events #(
    parameter int    WIDTH          = 4,
    parameter string POLARITY       = "HIGH",
    parameter int    SYNC_STAGES    = 2,
    parameter int    PRESS_CYCLES   = 50000,
    parameter int    RELEASE_CYCLES = 50000,
    parameter int    LONG_CYCLES    = 0
) (
    input logic          clk,
    input logic          reset_n,
    debounce_events_if.slave bus
);

    // A raw LOW-polarity input is active at 0. Inverting after the
    // synchronizer keeps the whole FSM active-high.
    localparam logic ACTIVE_LOW = (POLARITY == "LOW");
    // The synchronizer resets to the idle level of the pin, so releasing
    // reset with an idle input cannot look like an edge.
    localparam logic INACTIVE   = ACTIVE_LOW;

    // One qualification counter serves both directions. It is sized for the longer one.
    localparam int QMAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int QW   = $clog2(QMAX + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            localparam logic [QW-1:0] PRESS_LAST   = QW'(PRESS_CYCLES - 1);
            localparam logic [QW-1:0] RELEASE_LAST = QW'(RELEASE_CYCLES - 1);

            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   active;

            state_t                 state_reg;
            state_t                 state_next;
            logic [QW-1:0]          cnt_reg;
            logic [QW-1:0]          cnt_next;

            logic                   level_reg;
            logic                   level_next;
            logic                   press_reg;
            logic                   press_next;
            logic                   release_reg;
            logic                   release_next;

            // Shift the raw input through the metastability chain.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= {SYNC_STAGES{INACTIVE}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.data_in[gi]};
                end
            end

            assign active = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;

            // State and qualification counter registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next state: count consecutive agreeing samples. Any disagreement restarts.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    IDLE: begin
                        if (active) begin
                            if (PRESS_CYCLES == 1) begin
                                state_next = PRESSED;
                                cnt_next   = '0;
                            end else begin
                                state_next = PRESS_WAIT;
                                cnt_next   = QW'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!active) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == PRESS_LAST) begin
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + QW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!active) begin
                            if (RELEASE_CYCLES == 1) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end else begin
                                state_next = RELEASE_WAIT;
                                cnt_next   = QW'(1);
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (active) begin
                            // A short dropout is treated as a glitch. Return without any event.
                            state_next = PRESSED;
                            cnt_next   = '0;
                        end else if (cnt_reg == RELEASE_LAST) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + QW'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Outputs: level follows the qualified state, and pulses mark the transitions into or out of it.
            always_comb begin
                level_next   = 1'b0;
                press_next   = 1'b0;
                release_next = 1'b0;
                level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
                press_next   = (state_next == PRESSED) &&
                               ((state_reg == IDLE) || (state_reg == PRESS_WAIT));
                release_next = (state_next == IDLE) &&
                               ((state_reg == PRESSED) || (state_reg == RELEASE_WAIT));
            end

            // Register level and pulses so they change on the same edge as the state.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign bus.level[gi]         = level_reg;
            assign bus.press_pulse[gi]   = press_reg;
            assign bus.release_pulse[gi] = release_reg;

            if (LONG_CYCLES > 0) begin : g_long
                localparam int            HW        = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
                localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
                localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);

                logic [HW-1:0] hold_reg;
                logic [HW-1:0] hold_next;
                logic          long_pulse_reg;
                logic          long_pulse_next;
                logic          long_level_reg;
                logic          long_level_next;

                // Hold time: zero while released, saturating count while level is high.
                // A release on the reaching edge suppresses the long event.
                always_comb begin
                    hold_next       = hold_reg;
                    long_pulse_next = 1'b0;
                    long_level_next = 1'b0;
                    if (!level_reg) begin
                        hold_next = '0;
                    end else if (hold_reg != LONG_MAX) begin
                        hold_next = hold_reg + HW'(1);
                    end
                    long_pulse_next = level_reg && !release_next && (hold_reg == LONG_LAST);
                    long_level_next = level_next && (long_level_reg || long_pulse_next);
                end

                // Hold counter and long-press output registers.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        hold_reg       <= '0;
                        long_pulse_reg <= 1'b0;
                        long_level_reg <= 1'b0;
                    end else begin
                        hold_reg       <= hold_next;
                        long_pulse_reg <= long_pulse_next;
                        long_level_reg <= long_level_next;
                    end
                end

                assign bus.long_pulse[gi] = long_pulse_reg;
                assign bus.long_level[gi] = long_level_reg;
            end else begin : g_no_long
                assign bus.long_pulse[gi] = 1'b0;
                assign bus.long_level[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_debounce_events.sv
// Self-checking bench for debounce_events.
// There is one active-high instance and one active-low instance.
// Expected pulse events are queued when stimulus is driven and matched as the DUTs emit them.
module tb_debounce_events;

    localparam int W     = 4;
    localparam int SYNC  = 2;
    localparam int PRESS = 4;
    localparam int REL   = 3;
    localparam int LONG  = 10;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    debounce_events_if #(.WIDTH(W)) bus_h ();
    debounce_events_if #(.WIDTH(W)) bus_l ();

    debounce_events #(
        .WIDTH(W), .POLARITY("HIGH"), .SYNC_STAGES(SYNC),
        .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(REL), .LONG_CYCLES(LONG)
    ) dut_h (
        .clk(clk), .reset_n(reset_n), .bus(bus_h)
    );

    debounce_events #(
        .WIDTH(W), .POLARITY("LOW"), .SYNC_STAGES(SYNC),
        .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(REL), .LONG_CYCLES(LONG)
    ) dut_l (
        .clk(clk), .reset_n(reset_n), .bus(bus_l)
    );

    typedef struct {
        int at;
        int dut;
        int ch;
        int kind;
    } ev_t;

    ev_t   exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string kind_name[3] = '{"press", "release", "long"};

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic expect_ev(input int d, input int c, input int k, input int at);
        ev_t e;
        e.at = at; e.dut = d; e.ch = c; e.kind = k;
        exp_q.push_back(e);
    endtask

    function automatic logic pulse_bit(input int d, input int c, input int k);
        logic [W-1:0] v;
        if (d == 0) begin
            case (k)
                K_PRESS:   v = bus_h.press_pulse;
                K_RELEASE: v = bus_h.release_pulse;
                default:   v = bus_h.long_pulse;
            endcase
        end else begin
            case (k)
                K_PRESS:   v = bus_l.press_pulse;
                K_RELEASE: v = bus_l.release_pulse;
                default:   v = bus_l.long_pulse;
            endcase
        end
        return v[c];
    endfunction

    // Scoreboard: every observed pulse must match an expected event for this exact cycle.
    // Every expected event must be observed.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < 3; k++) begin
                    logic seen;
                    int   idx;
                    seen = pulse_bit(d, c, k);
                    idx  = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].at == cyc && exp_q[i].dut == d &&
                            exp_q[i].ch == c && exp_q[i].kind == k) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx >= 0) exp_q.delete(idx);
                    if (idx >= 0 || seen)
                        check($sformatf("sb_d%0d_ch%0d_%s", d, c, kind_name[k]),
                              int'(seen), (idx >= 0) ? 1 : 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, p, g, d, y, x;
        bus_h.data_in = '0;
        bus_l.data_in = '1;
        reset_n = 1'b0;
        repeat (3) step();

        // Reset state on both instances.
        check("rst_level_h", int'(bus_h.level), 0);
        check("rst_pulses_h", int'(bus_h.press_pulse | bus_h.release_pulse | bus_h.long_pulse), 0);
        check("rst_level_l", int'(bus_l.level | bus_l.long_level), 0);
        reset_n = 1'b1;
        repeat (8) step();
        check("idle_after_rst_h", int'(bus_h.level), 0);
        check("idle_after_rst_l", int'(bus_l.level), 0);

        // Clean press on ch0, held through the long-press time, then released.
        n = cyc;
        bus_h.data_in[0] = 1'b1;
        expect_ev(0, 0, K_PRESS, n + SYNC + PRESS);
        expect_ev(0, 0, K_LONG, n + SYNC + PRESS + LONG);
        wait_until(n + 5);  check("t1_level_pre", int'(bus_h.level[0]), 0);
        wait_until(n + 6);  check("t1_level", int'(bus_h.level[0]), 1);
        wait_until(n + 15); check("t1_long_level_pre", int'(bus_h.long_level[0]), 0);
        wait_until(n + 16); check("t1_long_level", int'(bus_h.long_level[0]), 1);
        wait_until(n + 20);
        bus_h.data_in[0] = 1'b0;
        expect_ev(0, 0, K_RELEASE, n + 20 + SYNC + REL);
        wait_until(n + 24); check("t1_long_level_hold", int'(bus_h.long_level[0]), 1);
        wait_until(n + 25); check("t1_level_off", int'(bus_h.level[0]), 0);
        check("t1_long_level_off", int'(bus_h.long_level[0]), 0);

        // Press chatter on ch1: three active samples then one inactive, never qualifies.
        for (int i = 0; i < 40; i++) begin
            bus_h.data_in[1] = ((i % 4) != 3);
            step();
        end
        check("t2_chatter_level", int'(bus_h.level[1]), 0);
        n = cyc;
        bus_h.data_in[1] = 1'b1;
        p = n + SYNC + PRESS;
        expect_ev(0, 1, K_PRESS, p);
        expect_ev(0, 1, K_LONG, p + LONG);
        wait_until(p); check("t2_level", int'(bus_h.level[1]), 1);

        // Release glitch on ch1: a two-cycle dropout is shorter than RELEASE_CYCLES.
        wait_until(p + 12);
        g = cyc;
        bus_h.data_in[1] = 1'b0;
        step(); step();
        bus_h.data_in[1] = 1'b1;
        wait_until(g + 10);
        check("t3_glitch_level", int'(bus_h.level[1]), 1);
        check("t3_glitch_long_level", int'(bus_h.long_level[1]), 1);
        d = cyc;
        bus_h.data_in[1] = 1'b0;
        expect_ev(0, 1, K_RELEASE, d + SYNC + REL);
        wait_until(d + 4); check("t3_level_pre", int'(bus_h.level[1]), 1);
        wait_until(d + 5); check("t3_level_off", int'(bus_h.level[1]), 0);

        // ch2 releases on the edge its hold count would reach LONG.
        // ch3 is pressed at the same time and held.
        n = cyc;
        bus_h.data_in[2] = 1'b1;
        bus_h.data_in[3] = 1'b1;
        p = n + SYNC + PRESS;
        expect_ev(0, 2, K_PRESS, p);
        expect_ev(0, 3, K_PRESS, p);
        expect_ev(0, 2, K_RELEASE, p + LONG);
        expect_ev(0, 3, K_LONG, p + LONG);
        wait_until(p + LONG - SYNC - REL);
        bus_h.data_in[2] = 1'b0;
        wait_until(p + 9);  check("t4_ch2_level_pre", int'(bus_h.level[2]), 1);
        wait_until(p + 10);
        check("t4_ch2_level_off", int'(bus_h.level[2]), 0);
        check("t4_ch2_long_level", int'(bus_h.long_level[2]), 0);
        check("t4_ch3_long_level", int'(bus_h.long_level[3]), 1);
        wait_until(p + 14);
        bus_h.data_in[3] = 1'b0;
        expect_ev(0, 3, K_RELEASE, p + 14 + SYNC + REL);
        wait_until(p + 19);
        check("t4_ch3_long_level_off", int'(bus_h.long_level[3]), 0);

        // Active-low instance: only ch0 driven low.
        n = cyc;
        bus_l.data_in = 4'hE;
        expect_ev(1, 0, K_PRESS, n + SYNC + PRESS);
        expect_ev(1, 0, K_LONG, n + SYNC + PRESS + LONG);
        wait_until(n + 6);  check("t5_low_level", int'(bus_l.level), 1);
        wait_until(n + 17); check("t5_low_long_level", int'(bus_l.long_level), 1);
        wait_until(n + 18);
        bus_l.data_in = 4'hF;
        expect_ev(1, 0, K_RELEASE, n + 18 + SYNC + REL);
        wait_until(n + 23); check("t5_low_level_off", int'(bus_l.level), 0);

        // Reset while ch0 is in RELEASE_WAIT: outputs drop at once and no release pulse occurs.
        n = cyc;
        bus_h.data_in[0] = 1'b1;
        expect_ev(0, 0, K_PRESS, n + SYNC + PRESS);
        wait_until(n + 8);
        y = cyc;
        bus_h.data_in[0] = 1'b0;
        wait_until(y + 3);
        check("t6_level_in_rw", int'(bus_h.level[0]), 1);
        reset_n = 1'b0;
        bus_h.data_in[0] = 1'b1;
        #1;
        check("t6_async_level", int'(bus_h.level), 0);
        check("t6_async_pulses", int'(bus_h.press_pulse | bus_h.release_pulse), 0);
        step(); step();
        check("t6_rst_level", int'(bus_h.level), 0);
        reset_n = 1'b1;
        x = cyc;
        expect_ev(0, 0, K_PRESS, x + SYNC + PRESS);
        expect_ev(0, 0, K_LONG, x + SYNC + PRESS + LONG);
        wait_until(x + 5); check("t6_fresh_level_pre", int'(bus_h.level[0]), 0);
        wait_until(x + 6); check("t6_fresh_level", int'(bus_h.level[0]), 1);
        wait_until(x + 20);
        check("t6_low_quiet", int'(bus_l.level), 0);

        check("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
